// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: assembles a big-endian byte stream into
// 32-bit words, writes them to consecutive addresses and holds the core meanwhile.
module imem_loader #(
  parameter int unsigned MEM_WIDTH = 32,
  parameter int unsigned MEM_DEPTH = 1024,
  parameter int unsigned ADDR_SIZE = 32,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_start,
  input  logic [10:0]          load_len,
  input  logic                 in_valid,
  input  logic [7:0]           in_data,
  output logic                 in_ready,
  output logic                 imem_wr_en,
  output logic [ADDR_SIZE-1:0] imem_wr_addr,
  output logic [MEM_WIDTH-1:0] imem_wr_data,
  output logic                 cpu_hold,
  output logic                 busy,
  output logic                 load_done,
  output logic                 load_err,
  output logic [31:0]          checksum
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RECV  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [ADDR_SIZE-1:0] BASE = ADDR_SIZE'(BASE_ADDR);

  logic [1:0]           state;
  logic [10:0]          len_q;
  logic [10:0]          word_cnt;
  logic [10:0]          word_cnt_next;
  logic [1:0]           byte_cnt;
  logic [MEM_WIDTH-1:0] word;
  logic [ADDR_SIZE-1:0] addr;
  logic                 hold_q;

  assign word_cnt_next = word_cnt + 11'd1;

  // Every output decodes straight from registered state, so none of them can
  // depend combinationally on in_valid, and addr/data are stable across WRITE.
  assign in_ready     = (state == RECV);
  assign imem_wr_en   = (state == WRITE);
  assign busy         = (state == RECV) || (state == WRITE);
  assign load_done    = (state == DONE);
  assign cpu_hold     = hold_q;
  assign imem_wr_addr = (state == WRITE) ? addr : '0;
  assign imem_wr_data = (state == WRITE) ? word : '0;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register in this block sees the pre-edge value of its neighbours.
    if (!rst_n) begin
      // NOTE: the datapath registers are reset too, because the write bus and
      // checksum must read zero straight after reset, not X.
      state    <= IDLE;
      len_q    <= '0;
      word_cnt <= '0;
      byte_cnt <= '0;
      word     <= '0;
      addr     <= BASE;
      hold_q   <= 1'b1;
      load_err <= 1'b0;
      checksum <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load_start) begin
            hold_q   <= 1'b1;
            load_err <= 1'b0;
            checksum <= '0;
            word_cnt <= '0;
            byte_cnt <= '0;
            addr     <= BASE;
            len_q    <= load_len;
            if (load_len == 11'd0) begin
              state <= DONE;
            end else if (32'(load_len) > MEM_DEPTH) begin
              load_err <= 1'b1;
              state    <= DONE;
            end else begin
              state <= RECV;
            end
          end
        end
        RECV: begin
          if (in_valid) begin
            word     <= {word[MEM_WIDTH-9:0], in_data};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) state <= WRITE;
          end
        end
        WRITE: begin
          checksum <= checksum + word;
          word_cnt <= word_cnt_next;
          addr     <= addr + ADDR_SIZE'(4);
          state    <= (word_cnt_next == len_q) ? DONE : RECV;
        end
        DONE: begin
          // Releasing the core here makes cpu_hold fall in the first IDLE cycle.
          hold_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: two instances (base 0x0 and 0x100) share
// one stimulus stream; a scoreboard queue per instance checks every write.
module tb_imem_loader;

  typedef struct {
    logic [31:0] off;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_start = 1'b0;
  logic [10:0] load_len = '0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;

  logic        in_ready0, wr_en0, hold0, busy0, done0, err0;
  logic [31:0] wr_addr0, wr_data0, sum0;
  logic        in_ready1, wr_en1, hold1, busy1, done1, err1;
  logic [31:0] wr_addr1, wr_data1, sum1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [7:0]  stream[$];
  int          wr_cyc_q[$];
  int          wr_cnt0 = 0;
  int          wr_cnt1 = 0;
  logic [31:0] last_addr0 = '0;
  logic [31:0] last_addr1 = '0;
  logic [31:0] exp_sum;
  logic [31:0] exp_off;
  int          start_cyc;

  imem_loader #(.BASE_ADDR(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .load_len(load_len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready0),
    .imem_wr_en(wr_en0), .imem_wr_addr(wr_addr0), .imem_wr_data(wr_data0),
    .cpu_hold(hold0), .busy(busy0), .load_done(done0), .load_err(err0),
    .checksum(sum0)
  );

  imem_loader #(.BASE_ADDR(32'h100)) dut1 (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .load_len(load_len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready1),
    .imem_wr_en(wr_en1), .imem_wr_addr(wr_addr1), .imem_wr_data(wr_data1),
    .cpu_hold(hold1), .busy(busy1), .load_done(done1), .load_err(err1),
    .checksum(sum1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Write monitors: every strobe must match the head of its instance's queue.
  always @(negedge clk) begin
    if (wr_en0 === 1'b1) begin
      exp_t e;
      wr_cnt0++;
      wr_cyc_q.push_back(cyc);
      last_addr0 = wr_addr0;
      check("wr_expected0", {31'b0, q0.size() != 0}, 32'd1);
      if (q0.size() != 0) begin
        e = q0.pop_front();
        check("wr_addr0", wr_addr0, e.off);
        check("wr_data0", wr_data0, e.data);
      end
    end
  end

  always @(negedge clk) begin
    if (wr_en1 === 1'b1) begin
      exp_t e;
      wr_cnt1++;
      last_addr1 = wr_addr1;
      check("wr_expected1", {31'b0, q1.size() != 0}, 32'd1);
      if (q1.size() != 0) begin
        e = q1.pop_front();
        check("wr_addr1", wr_addr1, 32'h100 + e.off);
        check("wr_data1", wr_data1, e.data);
      end
    end
  end

  task automatic start(input int len);
    @(negedge clk);
    load_start = 1'b1;
    load_len   = 11'(len);
    start_cyc  = cyc;
    exp_sum    = '0;
    exp_off    = '0;
    @(negedge clk);
    load_start = 1'b0;
    load_len   = '0;
  endtask

  task automatic add_word(input logic [31:0] w);
    exp_t e;
    stream.push_back(w[31:24]);
    stream.push_back(w[23:16]);
    stream.push_back(w[15:8]);
    stream.push_back(w[7:0]);
    e.off  = exp_off;
    e.data = w;
    q0.push_back(e);
    q1.push_back(e);
    exp_off = exp_off + 32'd4;
    exp_sum = exp_sum + w;
  endtask

  // Called at a negedge; streams the queued bytes, optionally stalling
  // stall_len cycles before byte stall_idx.
  task automatic send_stream(input int stall_idx, input int stall_len);
    for (int i = 0; i < stream.size(); i++) begin
      int waitc = 0;
      while (in_ready0 !== 1'b1 && waitc < 20) begin
        in_valid = 1'b0;
        @(negedge clk);
        waitc++;
      end
      if (waitc >= 20) begin
        check("in_ready_timeout", {31'b0, in_ready0}, 32'd1);
        break;
      end
      if (i == stall_idx) begin
        in_valid = 1'b0;
        repeat (stall_len) @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = stream[i];
      @(negedge clk);
    end
    in_valid = 1'b0;
    stream.delete();
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done0 !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("load_done_seen", {31'b0, done0}, 32'd1);
  endtask

  initial begin
    int base_wr;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_in_ready", {31'b0, in_ready0}, 32'd0);
    check("rst_wr_en", {31'b0, wr_en0}, 32'd0);
    check("rst_wr_addr1", wr_addr1, 32'd0);
    check("rst_wr_data", wr_data0, 32'd0);
    check("rst_busy", {31'b0, busy0}, 32'd0);
    check("rst_done", {31'b0, done0}, 32'd0);
    check("rst_err", {31'b0, err0}, 32'd0);
    check("rst_checksum", sum0, 32'd0);
    check("rst_cpu_hold", {31'b0, hold0}, 32'd1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_cpu_hold", {31'b0, hold0}, 32'd1);

    // Two words, no gaps: write/done/hold timing relative to the start cycle.
    wr_cyc_q.delete();
    start(2);
    check("recv_busy", {31'b0, busy0}, 32'd1);
    check("recv_in_ready", {31'b0, in_ready0}, 32'd1);
    add_word(32'h01098820);
    add_word(32'hAC110004);
    send_stream(-1, 0);
    wait_done(20);
    check("t1_done_cycle", 32'(cyc - start_cyc), 32'd11);
    check("t1_wr_count", 32'(wr_cyc_q.size()), 32'd2);
    if (wr_cyc_q.size() == 2) begin
      check("t1_wr_cycle0", 32'(wr_cyc_q[0] - start_cyc), 32'd5);
      check("t1_wr_cycle1", 32'(wr_cyc_q[1] - start_cyc), 32'd10);
    end
    check("t1_checksum0", sum0, exp_sum);
    check("t1_checksum1", sum1, exp_sum);
    check("t1_hold_in_done", {31'b0, hold0}, 32'd1);
    @(negedge clk);
    check("t1_hold_fall", {31'b0, hold0}, 32'd0);
    check("t1_hold_fall_cycle", 32'(cyc - start_cyc), 32'd12);
    check("t1_checksum_idle", sum0, exp_sum);

    // Same data with a 3-cycle stall between bytes 2 and 3.
    base_wr = wr_cnt0;
    start(2);
    add_word(32'h01098820);
    add_word(32'hAC110004);
    send_stream(2, 3);
    wait_done(20);
    check("t2_wr_count", 32'(wr_cnt0 - base_wr), 32'd2);
    check("t2_checksum1", sum1, exp_sum);
    check("t2_queue_empty", 32'(q1.size()), 32'd0);

    // Zero length, then an oversized length.
    base_wr = wr_cnt0;
    start(0);
    wait_done(5);
    check("t3_len0_err", {31'b0, err0}, 32'd0);
    @(negedge clk);
    start(1025);
    wait_done(5);
    check("t3_len1025_err", {31'b0, err0}, 32'd1);
    repeat (3) @(negedge clk);
    check("t3_err_sticky", {31'b0, err0}, 32'd1);
    check("t3_no_writes0", 32'(wr_cnt0 - base_wr), 32'd0);
    check("t3_no_writes1", 32'(wr_cnt1 - base_wr), 32'd0);

    // A second load_start during RECV is ignored.
    base_wr = wr_cnt0;
    start(2);
    load_start = 1'b1;
    load_len   = 11'd1;
    @(negedge clk);
    load_start = 1'b0;
    load_len   = '0;
    add_word(32'h12345678);
    add_word(32'h9ABCDEF0);
    send_stream(-1, 0);
    wait_done(20);
    check("t4_wr_count", 32'(wr_cnt0 - base_wr), 32'd2);
    check("t4_err_cleared", {31'b0, err0}, 32'd0);
    check("t4_checksum", sum0, exp_sum);

    // Reset after two bytes abandons the load; the core stays held.
    base_wr = wr_cnt0;
    repeat (2) @(negedge clk);
    start(1);
    in_valid = 1'b1;
    in_data  = 8'hDE;
    @(negedge clk);
    in_data  = 8'hAD;
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    repeat (2) @(negedge clk);
    check("t5_rst_busy", {31'b0, busy0}, 32'd0);
    check("t5_rst_hold", {31'b0, hold0}, 32'd1);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("t5_idle_hold", {31'b0, hold0}, 32'd1);
    check("t5_no_abort_write", 32'(wr_cnt0 - base_wr), 32'd0);
    start(1);
    add_word(32'h8C0A0004);
    send_stream(-1, 0);
    wait_done(20);
    check("t5_hold_at_done", {31'b0, hold0}, 32'd1);
    check("t5_wr_count", 32'(wr_cnt0 - base_wr), 32'd1);
    check("t5_addr0", last_addr0, 32'h0);
    @(negedge clk);
    check("t5_hold_released", {31'b0, hold0}, 32'd0);

    // Full-depth load.
    base_wr = wr_cnt0;
    start(1024);
    for (int i = 0; i < 1024; i++) add_word($urandom);
    send_stream(-1, 0);
    wait_done(20);
    check("t6_wr_count0", 32'(wr_cnt0 - base_wr), 32'd1024);
    check("t6_wr_count1", 32'(wr_cnt1 - base_wr), 32'd1024);
    check("t6_last_addr0", last_addr0, 32'hFFC);
    check("t6_last_addr1", last_addr1, 32'h10FC);
    check("t6_checksum0", sum0, exp_sum);
    check("t6_checksum1", sum1, exp_sum);
    check("t6_queue_empty", 32'(q0.size()), 32'd0);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time writer for the instruction memory. It accepts a big-endian byte stream over a valid/ready handshake and assembles each group of four bytes into a 32-bit instruction word. Each word is written through a single-cycle write port into consecutive word-aligned addresses, starting at `BASE_ADDR`. The loader holds the single-cycle MIPS core in reset for the whole load, then releases it and reports a word count and checksum.

## Interface
Parameters:
- `MEM_WIDTH`, 32: instruction word width; fixed at 32.
- `MEM_DEPTH`, 1024: number of words in the instruction memory.
- `ADDR_SIZE`, 32: width of the byte address.
- `BASE_ADDR`, 0: byte address of the first written word; must be a multiple of 4.

Ports:
- `clk`  in  1  the single clock; all state updates on its rising edge.
- `rst_n`  in  1  reset; synchronous and active-low.
- `load_start`  in  1  single-cycle request to begin a load; sampled only in IDLE.
- `load_len`  in  11  number of words to load; sampled together with `load_start`.
- `in_valid`  in  1  a byte is presented on `in_data`.
- `in_data`  in  8  the presented byte; the first byte of each word becomes bits [31:24].
- `in_ready`  out  1  the loader can accept a byte.
- `imem_wr_en`  out  1  write strobe to the instruction memory.
- `imem_wr_addr`  out  ADDR_SIZE  byte address of the word being written; always word-aligned.
- `imem_wr_data`  out  MEM_WIDTH  the word being written.
- `cpu_hold`  out  1  holds the core in reset while high.
- `busy`  out  1  a load is in progress.
- `load_done`  out  1  one-cycle pulse at the end of a load.
- `load_err`  out  1  sticky error flag; cleared by the next accepted `load_start`.
- `checksum`  out  32  modulo-2^32 sum of all words written in the current or most recent load.

## Operation
- States: IDLE, RECV, WRITE, DONE.
- IDLE:
  - `in_ready`=0.
  - `load_start` with 0 < `load_len` ≤ `MEM_DEPTH`: latch `load_len`, set the address register to `BASE_ADDR`, clear the byte count, word count, checksum and `load_err`, then go to RECV.
  - `load_start` with `load_len`=0: go to DONE with no writes.
  - `load_start` with `load_len` > `MEM_DEPTH`: set `load_err`=1, make no writes, go to DONE.
- RECV:
  - `in_ready`=1.
  - A byte is accepted when `in_valid` && `in_ready`.
  - Each accepted byte shifts in: word = {word[23:0], `in_data`}. The byte count advances 0→1→2→3.
  - When the byte with count 3 is accepted, go to WRITE.
  - Cycles with `in_valid`=0 are stalls; the state is held.
- WRITE:
  - Exactly one cycle, with `in_ready`=0 and `imem_wr_en`=1.
  - `imem_wr_addr` is the current address and `imem_wr_data` is the assembled word.
  - `checksum` += word, the word count increments and the address advances by 4.
  - If the new word count equals the latched length, go to DONE; otherwise go to RECV.
- DONE:
  - One cycle with `load_done`=1, then go to IDLE.
- `load_start` outside IDLE is ignored.
- Address overflow is impossible: `load_len` ≤ `MEM_DEPTH` is checked at start. The user must ensure that `BASE_ADDR` + 4·`MEM_DEPTH` fits in `ADDR_SIZE`.

## Timing
- Reset (`rst_n`=0 at a clock edge) forces IDLE. All outputs read 0 from the next cycle, except `cpu_hold`=1. The address register is set to `BASE_ADDR`.
  - After reset the core is therefore held until the first load completes or is rejected.
  - A reset mid-load abandons the load. The partial word is discarded and there are no further writes.
- `cpu_hold`:
  - Is 1 from reset and in RECV, WRITE and DONE.
  - Drops to 0 in the IDLE cycle after DONE, and stays 0 in IDLE until the next accepted `load_start`.
  - Rises in the cycle after an accepted `load_start`.
- `busy` is 1 in RECV and WRITE.
- Throughput and latency:
  - Minimum 5 cycles per word: 4 byte acceptances plus 1 WRITE cycle.
  - `imem_wr_en` rises in the cycle after the 4th byte of a word is accepted.
  - `load_done` follows the last WRITE cycle by exactly one cycle.
- `in_ready` is registered from the state only; it never depends combinationally on `in_valid`.
- `imem_wr_addr`/`imem_wr_data` are don't-care when `imem_wr_en`=0, but must not glitch while `imem_wr_en`=1.
- `checksum` and `load_err` hold their values through IDLE until the next accepted start.

## Test plan
- Reset, then `load_start` with `load_len`=2 and bytes 01 09 88 20 AC 11 00 04 streamed without gaps. Required:
  - Writes of 32'h01098820 @0x0 and 32'hAC110004 @0x4.
  - `imem_wr_en` high in cycles 5 and 10 after the start.
  - `load_done` in cycle 11; `checksum`=32'hAD1A8824; `cpu_hold` falls in cycle 12.
- Same stream with `in_valid` low for 3 cycles between bytes 2 and 3, and `BASE_ADDR`=0x100. Required: identical data written @0x100 and @0x104; no write while stalled.
- `load_len`=0, then `load_len`=1025. Required:
  - No writes in either case; `load_done` pulse each time.
  - `load_err`=0 after the first case and 1 after the second.
- `load_start` pulsed again during RECV. Required: ignored; the original length completes and the word count is unchanged.
- Assert `rst_n`=0 after 2 bytes of word 1, release it, then load 1 word 8C 0A 00 04. Required:
  - No write from the aborted load; `cpu_hold` stays high until the new load completes.
  - The single write is 32'h8C0A0004 @`BASE_ADDR`.
- Full-depth load with `load_len`=1024. Required:
  - The last write is @`BASE_ADDR`+0xFFC.
  - Exactly 1024 `imem_wr_en` pulses.
  - `checksum` equals the modulo-2^32 sum computed by the bench model.
